// File: rtl/machine_top_entity.sv
// Accumulator machine: one 8-bit instruction per clock on a
// 12-bit accumulator plus a four-entry register file.
module machine_top_entity (
  input  logic        system1000,
  input  logic        system1000_rstn,
  input  logic [7:0]  x,
  output logic [11:0] result
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_SHLI = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_CLR  = 4'hF;

  logic [11:0] acc;
  logic [11:0] acc_nxt;
  logic [11:0] rf [4];
  logic [3:0]  op;
  logic [3:0]  imm;
  logic [11:0] imm_ext;
  logic [1:0]  rsel;
  logic [11:0] rval;
  logic        big_sh;

  assign op      = x[7:4];
  assign imm     = x[3:0];
  assign imm_ext = {8'h00, imm};
  assign rsel    = x[1:0];
  assign rval    = rf[rsel];
  assign big_sh  = (imm >= 4'd12);
  assign result  = acc;

  always_comb begin
    acc_nxt = acc;
    unique case (op)
      OP_NOP:  acc_nxt = acc;
      OP_LDI:  acc_nxt = imm_ext;
      OP_SHLI: acc_nxt = {acc[7:0], imm};
      OP_ADDI: acc_nxt = acc + imm_ext;
      OP_SUBI: acc_nxt = acc - imm_ext;
      OP_AND:  acc_nxt = acc & rval;
      OP_OR:   acc_nxt = acc | rval;
      OP_XOR:  acc_nxt = acc ^ rval;
      OP_ADD:  acc_nxt = acc + rval;
      OP_SUB:  acc_nxt = acc - rval;
      OP_ST:   acc_nxt = acc;
      OP_LD:   acc_nxt = rval;
      OP_NOT:  acc_nxt = ~acc;
      OP_SHL:  acc_nxt = big_sh ? 12'h000 : (acc << imm);
      OP_SHR:  acc_nxt = big_sh ? 12'h000 : (acc >> imm);
      OP_CLR:  acc_nxt = 12'h000;
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      acc <= 12'h000;
    end else begin
      acc <= acc_nxt;
    end
  end

  // ST writes the pre-edge ACC; CLR wipes every entry at once
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < 4; i++) rf[i] <= 12'h000;
    end else if (op == OP_CLR) begin
      for (int i = 0; i < 4; i++) rf[i] <= 12'h000;
    end else if (op == OP_ST) begin
      rf[rsel] <= acc;
    end
  end

endmodule

// File: tb/tb_machine_top_entity.sv
// Self-checking bench for machine_top_entity: directed sequences
// plus random instruction streams against an arithmetic model.
module tb_machine_top_entity;

  logic        clk;
  logic        rstn;
  logic [7:0]  x;
  logic [11:0] result;

  int n_chk;
  int n_fail;

  int m_acc;
  int m_r [4];

  machine_top_entity dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .x               (x),
    .result          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [11:0] got,
    input logic [11:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_acc = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic m_exec(input logic [7:0] ins);
    int op;
    int imm;
    int rv;
    int rs;
    op  = int'(ins[7:4]);
    imm = int'(ins[3:0]);
    rs  = int'(ins[1:0]);
    rv  = m_r[rs];
    case (op)
      1:  m_acc = imm;
      2:  m_acc = (m_acc % 256) * 16 + imm;
      3:  m_acc = (m_acc + imm) % 4096;
      4:  m_acc = (m_acc - imm + 4096) % 4096;
      5:  m_acc = m_acc & rv;
      6:  m_acc = m_acc | rv;
      7:  m_acc = m_acc ^ rv;
      8:  m_acc = (m_acc + rv) % 4096;
      9:  m_acc = (m_acc - rv + 4096) % 4096;
      10: m_r[rs] = m_acc;
      11: m_acc = rv;
      12: m_acc = 4095 - m_acc;
      13: m_acc = (imm >= 12) ? 0 : (m_acc * (1 << imm)) % 4096;
      14: m_acc = (imm >= 12) ? 0 : m_acc / (1 << imm);
      15: begin
        m_acc = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
      end
      default: ;
    endcase
  endtask

  // drive one instruction, clock it, compare against the model
  task automatic exec(input logic [7:0] ins, input string tag);
    x = ins;
    @(posedge clk);
    m_exec(ins);
    #1;
    check(tag, result, 12'(m_acc));
  endtask

  task automatic exec_k(
    input logic [7:0]  ins,
    input string       tag,
    input logic [11:0] exp
  );
    exec(ins, tag);
    check({tag, "_k"}, result, exp);
  endtask

  task automatic async_reset(input int hold);
    #2;
    rstn = 1'b0;
    m_reset();
    #1;
    check("rst_async", result, 12'h000);
    for (int i = 0; i < hold; i++) begin
      x = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold", result, 12'h000);
    end
    @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    x      = 8'hFF;
    rstn   = 1'b1;
    m_reset();
    #2;
    rstn = 1'b0;
    #1;
    check("por_noclk", result, 12'h000);
    repeat (3) begin
      x = 8'($urandom);
      @(posedge clk);
      #1;
      check("por_hold", result, 12'h000);
    end
    @(negedge clk);
    #3;
    rstn = 1'b1;

    exec_k(8'h15, "ldi5", 12'h005);
    exec_k(8'h3F, "addi", 12'h014);

    exec_k(8'h1F, "ldif", 12'h00F);
    exec_k(8'h2F, "shli1", 12'h0FF);
    exec_k(8'h2F, "shli2", 12'hFFF);
    exec_k(8'h31, "wrap", 12'h000);

    exec_k(8'h13, "ldi3", 12'h003);
    exec_k(8'hA2, "st2", 12'h003);
    exec_k(8'h10, "ldi0", 12'h000);
    exec_k(8'hB2, "ld2", 12'h003);
    exec_k(8'h92, "sub2", 12'h000);
    exec_k(8'h41, "subi", 12'hFFF);

    exec_k(8'h18, "b800a", 12'h008);
    exec_k(8'h20, "b800b", 12'h080);
    exec_k(8'h20, "b800c", 12'h800);
    exec_k(8'hEB, "shr11", 12'h001);
    exec_k(8'hDC, "shl12", 12'h000);
    exec_k(8'hC0, "not", 12'hFFF);

    exec_k(8'h1A, "a5a", 12'h00A);
    exec_k(8'h25, "a5b", 12'h0A5);
    exec_k(8'hA0, "st0", 12'h0A5);
    exec_k(8'hA1, "st1", 12'h0A5);
    exec_k(8'hA2, "st2b", 12'h0A5);
    exec_k(8'hAF, "st3x", 12'h0A5);
    exec_k(8'hB3, "ld3pre", 12'h0A5);
    exec_k(8'h10, "ldi0b", 12'h000);
    exec_k(8'hB7, "ld3x", 12'h0A5);
    exec_k(8'hF0, "clr", 12'h000);
    exec_k(8'hB3, "ld3clr", 12'h000);
    exec_k(8'hB0, "ld0clr", 12'h000);

    exec_k(8'h1C, "ldic", 12'h00C);
    async_reset(2);
    exec_k(8'h17, "post_rst", 12'h007);

    for (int i = 0; i < 800; i++) begin
      logic [7:0] ins;
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF && ($urandom % 4) != 0)
        ins[7:4] = 4'($urandom_range(0, 14));
      exec(ins, "rand");
      if (($urandom % 100) == 0) async_reset(int'($urandom % 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
